// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RISC-V memory stage: data-bus handshake, lane steering, MEM/WB register
package mem_stage_pkg;
    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_CSR = 2'd3
    } result_src_e;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter bit WAIT_STORE_RSP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  mem_size_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic        write_rd_i,
    input  result_src_e result_srcM_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] csr_rdata_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        misaligned_o,
    output logic        write_rd_o,
    output result_src_e result_srcW_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] alu_result_o,
    output logic [31:0] lsu_rdata_o,
    output logic [31:0] csr_rdata_o
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_GNT    = 2'd1,
        S_WAIT_RVALID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        write_rd_q, write_rd_d;
    result_src_e result_src_q, result_src_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic [31:0] csr_rdata_q, csr_rdata_d;

    logic        mem_op;
    logic        misaligned;
    logic        access;
    logic        store_fast;
    logic        req;
    logic        rsp_done;
    logic        gnt_done;
    logic        stall;
    logic [1:0]  byte_off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign byte_off   = alu_result_i[1:0];
    assign mem_op     = valid_i & (is_load_i | is_store_i);
    assign store_fast = is_store_i & ~WAIT_STORE_RSP;

    always_comb begin
        misaligned = 1'b0;
        be         = 4'b1111;
        wdata      = store_data_i;
        case (mem_size_i)
            2'd0: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                misaligned = byte_off[0];
                be         = 4'b0011 << {byte_off[1], 1'b0};
                wdata      = {2{store_data_i[15:0]}};
            end
            default: begin
                misaligned = |byte_off;
            end
        endcase
    end

    assign access = mem_op & ~misaligned;

    // Load data arrives word-aligned; shift the addressed lane down to bit 0 before extending.
    always_comb begin
        shifted  = dmem_rdata_i >> {byte_off, 3'b000};
        load_ext = shifted;
        case (mem_size_i)
            2'd0: load_ext = load_unsigned_i ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = load_unsigned_i ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req      = 1'b0;
        rsp_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    req = 1'b1;
                    if (dmem_gnt_i) begin
                        state_d = store_fast ? S_IDLE : S_WAIT_RVALID;
                    end else begin
                        state_d = S_WAIT_GNT;
                    end
                end
            end
            S_WAIT_GNT: begin
                req = 1'b1;
                if (dmem_gnt_i) begin
                    state_d = store_fast ? S_IDLE : S_WAIT_RVALID;
                end
            end
            S_WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    state_d  = S_IDLE;
                    rsp_done = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A store that needs no response retires in its grant cycle.
    assign gnt_done = req & dmem_gnt_i & store_fast;
    assign stall    = access & ~rsp_done & ~gnt_done;

    always_comb begin
        write_rd_d   = write_rd_q;
        result_src_d = result_src_q;
        rd_addr_d    = rd_addr_q;
        alu_result_d = alu_result_q;
        lsu_rdata_d  = lsu_rdata_q;
        csr_rdata_d  = csr_rdata_q;
        if (stall || (mem_op && misaligned)) begin
            write_rd_d = 1'b0;
        end else begin
            write_rd_d   = valid_i & write_rd_i;
            result_src_d = result_srcM_i;
            rd_addr_d    = rd_addr_i;
            alu_result_d = alu_result_i;
            csr_rdata_d  = csr_rdata_i;
            if (rsp_done && is_load_i) begin
                lsu_rdata_d = load_ext;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            write_rd_q   <= 1'b0;
            result_src_q <= RES_ALU;
            rd_addr_q    <= 5'd0;
            alu_result_q <= 32'h0;
            lsu_rdata_q  <= 32'h0;
            csr_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_rd_q   <= write_rd_d;
            result_src_q <= result_src_d;
            rd_addr_q    <= rd_addr_d;
            alu_result_q <= alu_result_d;
            lsu_rdata_q  <= lsu_rdata_d;
            csr_rdata_q  <= csr_rdata_d;
        end
    end

    assign dmem_req_o    = req;
    assign dmem_we_o     = is_store_i;
    assign dmem_be_o     = be;
    assign dmem_addr_o   = {alu_result_i[31:2], 2'b00};
    assign dmem_wdata_o  = wdata;
    assign stall_o       = stall;
    assign misaligned_o  = mem_op & misaligned;
    assign write_rd_o    = write_rd_q;
    assign result_srcW_o = result_src_q;
    assign rd_addr_o     = rd_addr_q;
    assign alu_result_o  = alu_result_q;
    assign lsu_rdata_o   = lsu_rdata_q;
    assign csr_rdata_o   = csr_rdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        valid_i, is_load_i, is_store_i, load_unsigned_i, write_rd_i;
    logic [1:0]  mem_size_i;
    logic [31:0] alu_result_i, store_data_i, csr_rdata_i;
    result_src_e result_srcM_i;
    logic [4:0]  rd_addr_i;
    logic        gnt, rvalid, gnt0, rvalid0;
    logic [31:0] rdata;

    logic        req, we, stall, mis, wr;
    logic [3:0]  be;
    logic [31:0] addr, wdata, alu_o, lsu_o, csr_o;
    result_src_e src_o;
    logic [4:0]  rd_o;

    logic        req0, we0, stall0, mis0, wr0;
    logic [3:0]  be0;
    logic [31:0] addr0, wdata0, alu0, lsu0, csr0;
    result_src_e src0;
    logic [4:0]  rd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_stage #(.WAIT_STORE_RSP(1'b1)) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .mem_size_i(mem_size_i), .load_unsigned_i(load_unsigned_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .write_rd_i(write_rd_i),
        .result_srcM_i(result_srcM_i), .rd_addr_i(rd_addr_i), .csr_rdata_i(csr_rdata_i),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_be_o(be), .dmem_addr_o(addr),
        .dmem_wdata_o(wdata), .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
        .stall_o(stall), .misaligned_o(mis), .write_rd_o(wr), .result_srcW_o(src_o),
        .rd_addr_o(rd_o), .alu_result_o(alu_o), .lsu_rdata_o(lsu_o), .csr_rdata_o(csr_o)
    );

    mem_stage #(.WAIT_STORE_RSP(1'b0)) dut0 (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .mem_size_i(mem_size_i), .load_unsigned_i(load_unsigned_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i), .write_rd_i(write_rd_i),
        .result_srcM_i(result_srcM_i), .rd_addr_i(rd_addr_i), .csr_rdata_i(csr_rdata_i),
        .dmem_req_o(req0), .dmem_we_o(we0), .dmem_be_o(be0), .dmem_addr_o(addr0),
        .dmem_wdata_o(wdata0), .dmem_gnt_i(gnt0), .dmem_rvalid_i(rvalid0), .dmem_rdata_i(rdata),
        .stall_o(stall0), .misaligned_o(mis0), .write_rd_o(wr0), .result_srcW_o(src0),
        .rd_addr_o(rd0), .alu_result_o(alu0), .lsu_rdata_o(lsu0), .csr_rdata_o(csr0)
    );

    typedef struct {
        logic        vld, ld, st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] a, sd, rdata;
        logic        wr;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        exp_req, exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_lsu;
        logic        exp_wr;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        valid_i = 0; is_load_i = 0; is_store_i = 0; mem_size_i = 0; load_unsigned_i = 0;
        alu_result_i = 0; store_data_i = 0; write_rd_i = 0; result_srcM_i = RES_ALU;
        rd_addr_i = 0; csr_rdata_i = 0; gnt = 0; rvalid = 0; gnt0 = 0; rvalid0 = 0; rdata = 0;
    endtask

    task automatic drive(input vec_t v, input int i);
        valid_i = v.vld; is_load_i = v.ld; is_store_i = v.st; mem_size_i = v.size;
        load_unsigned_i = v.uns; alu_result_i = v.a; store_data_i = v.sd;
        write_rd_i = v.wr; rd_addr_i = v.rd; result_srcM_i = result_src_e'(v.src);
        csr_rdata_i = 32'hC000_0000 | 32'(i);
    endtask

    task automatic apply(input int i);
        vec_t v;
        v = tbl[i];
        drive(v, i);
        gnt = 1; rvalid = 0; rdata = 0;
        #1;
        chk($sformatf("v%0d misaligned", i), 32'(mis), 32'(v.exp_mis));
        chk($sformatf("v%0d req", i), 32'(req), 32'(v.exp_req));
        chk($sformatf("v%0d stall", i), 32'(stall), 32'(v.exp_req));
        if (v.exp_req) begin
            chk($sformatf("v%0d be", i), 32'(be), 32'(v.exp_be));
            chk($sformatf("v%0d addr", i), addr, {v.a[31:2], 2'b00});
            chk($sformatf("v%0d we", i), 32'(we), 32'(v.st));
            if (v.st) chk($sformatf("v%0d wdata", i), wdata, v.exp_wdata);
        end
        @(posedge clk); #1;
        if (v.exp_req) begin
            chk($sformatf("v%0d bubble", i), 32'(wr), 0);
            gnt = 0; rvalid = 1; rdata = v.rdata;
            #1;
            chk($sformatf("v%0d rsp stall", i), 32'(stall), 0);
            chk($sformatf("v%0d rsp req", i), 32'(req), 0);
            @(posedge clk); #1;
            rvalid = 0;
        end
        chk($sformatf("v%0d write_rd", i), 32'(wr), 32'(v.exp_wr));
        if (v.exp_wr) begin
            chk($sformatf("v%0d rd_addr", i), 32'(rd_o), 32'(v.rd));
            chk($sformatf("v%0d alu_result", i), alu_o, v.a);
            chk($sformatf("v%0d result_src", i), 32'(src_o), 32'(v.src));
            chk($sformatf("v%0d csr_rdata", i), csr_o, 32'hC000_0000 | 32'(i));
        end
        if (v.ld && v.exp_req) chk($sformatf("v%0d lsu_rdata", i), lsu_o, v.exp_lsu);
    endtask

    initial begin
        //          vld ld st sz uns addr          sd            rdata         wr rd src req mis be       wdata         lsu           wr
        tbl[0]  = '{1, 0, 0, 0, 0, 32'h0000_1234, 0,            0,            1, 5,  3, 0, 0, 4'b0000, 0,            0,            1};
        tbl[1]  = '{1, 1, 0, 0, 0, 32'h0000_1003, 0,            32'h80FF_FFFF, 1, 6,  1, 1, 0, 4'b1000, 0,            32'hFFFF_FF80, 1};
        tbl[2]  = '{1, 1, 0, 0, 1, 32'h0000_1003, 0,            32'h80FF_FFFF, 1, 7,  1, 1, 0, 4'b1000, 0,            32'h0000_0080, 1};
        tbl[3]  = '{1, 1, 0, 1, 0, 32'h0000_1002, 0,            32'h8001_1234, 1, 8,  1, 1, 0, 4'b1100, 0,            32'hFFFF_8001, 1};
        tbl[4]  = '{1, 1, 0, 1, 1, 32'h0000_1000, 0,            32'h8001_F234, 1, 9,  1, 1, 0, 4'b0011, 0,            32'h0000_F234, 1};
        tbl[5]  = '{1, 1, 0, 2, 0, 32'h0000_1008, 0,            32'hDEAD_BEEF, 1, 10, 1, 1, 0, 4'b1111, 0,            32'hDEAD_BEEF, 1};
        tbl[6]  = '{1, 1, 0, 0, 0, 32'h0000_1001, 0,            32'h1234_5678, 1, 11, 1, 1, 0, 4'b0010, 0,            32'h0000_0056, 1};
        tbl[7]  = '{1, 1, 0, 2, 0, 32'h0000_3001, 0,            0,            1, 12, 1, 0, 1, 4'b0000, 0,            0,            0};
        tbl[8]  = '{1, 1, 0, 1, 0, 32'h0000_3003, 0,            0,            1, 12, 1, 0, 1, 4'b0000, 0,            0,            0};
        tbl[9]  = '{1, 0, 1, 0, 0, 32'h0000_2001, 32'h0000_00AB, 0,            0, 0,  0, 1, 0, 4'b0010, 32'hABAB_ABAB, 0,            0};
        tbl[10] = '{1, 0, 1, 2, 0, 32'h0000_2004, 32'h1122_3344, 0,            0, 0,  0, 1, 0, 4'b1111, 32'h1122_3344, 0,            0};
        tbl[11] = '{1, 0, 1, 1, 0, 32'h0000_2001, 32'h0000_1234, 0,            0, 0,  0, 0, 1, 4'b0000, 0,            0,            0};
        tbl[12] = '{1, 1, 0, 3, 0, 32'h0000_1004, 0,            32'hCAFE_F00D, 1, 13, 1, 1, 0, 4'b1111, 0,            32'hCAFE_F00D, 1};
        tbl[13] = '{0, 1, 0, 2, 0, 32'h0000_1000, 0,            0,            1, 14, 1, 0, 0, 4'b0000, 0,            0,            0};
        tbl[14] = '{1, 0, 1, 1, 0, 32'h0000_2006, 32'h0000_BEEF, 0,            0, 0,  0, 1, 0, 4'b1100, 32'hBEEF_BEEF, 0,            0};

        idle_inputs();
        rstn_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset write_rd", 32'(wr), 0);
        chk("reset alu_result", alu_o, 0);
        chk("reset lsu_rdata", lsu_o, 0);
        chk("reset req", 32'(req), 0);
        chk("reset stall", 32'(stall), 0);
        chk("reset misaligned", 32'(mis), 0);
        rstn_i = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) apply(i);

        // SH with grant held off three cycles, response two cycles after grant
        drive('{1, 0, 1, 1, 0, 32'h0000_2002, 32'hAAAA_5678, 0, 0, 0, 0, 1, 0, 4'b1100, 0, 0, 0}, 20);
        gnt = 0; rvalid = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("sh wait%0d req", c), 32'(req), 1);
            chk($sformatf("sh wait%0d be", c), 32'(be), 32'b1100);
            chk($sformatf("sh wait%0d wdata", c), wdata, 32'h5678_5678);
            chk($sformatf("sh wait%0d stall", c), 32'(stall), 1);
            @(posedge clk); #1;
            chk($sformatf("sh wait%0d bubble", c), 32'(wr), 0);
        end
        gnt = 1;
        #1;
        chk("sh gnt req", 32'(req), 1);
        chk("sh gnt stall", 32'(stall), 1);
        @(posedge clk); #1;
        gnt = 0;
        #1;
        chk("sh post-gnt req", 32'(req), 0);
        chk("sh post-gnt stall", 32'(stall), 1);
        @(posedge clk); #1;
        rvalid = 1;
        #1;
        chk("sh rsp stall", 32'(stall), 0);
        @(posedge clk); #1;
        rvalid = 0;
        chk("sh done write_rd", 32'(wr), 0);
        valid_i = 0;
        #1;
        chk("sh back idle req", 32'(req), 0);

        // Reset while a load waits for its response; the late response must be dropped
        drive('{1, 1, 0, 2, 0, 32'h0000_1000, 0, 0, 1, 3, 1, 1, 0, 4'b1111, 0, 0, 1}, 21);
        gnt = 1;
        #1;
        chk("rst ld req", 32'(req), 1);
        @(posedge clk); #1;
        gnt = 0;
        chk("rst ld waiting stall", 32'(stall), 1);
        idle_inputs();
        rstn_i = 0;
        #1;
        chk("rst mid write_rd", 32'(wr), 0);
        chk("rst mid lsu_rdata", lsu_o, 0);
        chk("rst mid alu_result", alu_o, 0);
        chk("rst mid rd_addr", 32'(rd_o), 0);
        chk("rst mid csr_rdata", csr_o, 0);
        chk("rst mid stall", 32'(stall), 0);
        @(posedge clk); #1;
        rstn_i = 1;
        @(posedge clk); #1;
        rvalid = 1; rdata = 32'hFFFF_FFFF;
        #1;
        chk("late rvalid stall", 32'(stall), 0);
        chk("late rvalid req", 32'(req), 0);
        @(posedge clk); #1;
        rvalid = 0;
        chk("late rvalid lsu_rdata", lsu_o, 0);
        chk("late rvalid write_rd", 32'(wr), 0);

        // WAIT_STORE_RSP=0: SW granted at once retires without stalling
        drive('{1, 0, 1, 2, 0, 32'h0000_4000, 32'h55AA_33CC, 0, 0, 0, 0, 1, 0, 4'b1111, 0, 0, 0}, 22);
        gnt0 = 1; gnt = 1;
        #1;
        chk("fast sw req", 32'(req0), 1);
        chk("fast sw we", 32'(we0), 1);
        chk("fast sw be", 32'(be0), 32'b1111);
        chk("fast sw addr", addr0, 32'h0000_4000);
        chk("fast sw wdata", wdata0, 32'h55AA_33CC);
        chk("fast sw stall", 32'(stall0), 0);
        chk("slow sw stall", 32'(stall), 1);
        @(posedge clk); #1;
        idle_inputs();
        rvalid = 1; rvalid0 = 1;
        #1;
        chk("fast sw idle req", 32'(req0), 0);
        chk("fast sw idle stall", 32'(stall0), 0);
        @(posedge clk); #1;
        rvalid = 0; rvalid0 = 0;
        chk("fast sw write_rd", 32'(wr0), 0);
        drive('{1, 0, 0, 0, 0, 32'h0000_0777, 0, 0, 1, 17, 0, 0, 0, 4'b0000, 0, 0, 1}, 23);
        #1;
        chk("fast alu stall", 32'(stall0), 0);
        @(posedge clk); #1;
        chk("fast alu write_rd", 32'(wr0), 1);
        chk("fast alu rd_addr", 32'(rd0), 17);
        chk("fast alu result", alu0, 32'h0000_0777);
        idle_inputs();
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
